// File: rtl/lsu_pkg.sv
// Shared types and helpers for the LSU load path.
//   load_size_e : encoded access size (B/H/W/D) as carried on req_size_in
//   ld_state_e  : states of the load sequencing FSM
//   byte_off_w  : width of the byte offset within one bus beat (XLEN/8 bytes)
package lsu_pkg;

  typedef enum logic [1:0] {
    LS_B = 2'b00,
    LS_H = 2'b01,
    LS_W = 2'b10,
    LS_D = 2'b11
  } load_size_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ0  = 3'd1,
    ST_WAIT0 = 3'd2,
    ST_REQ1  = 3'd3,
    ST_WAIT1 = 3'd4,
    ST_RESP  = 3'd5
  } ld_state_e;

  function automatic int byte_off_w(input int xlen);
    return $clog2(xlen / 8);
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Combinational merge / align / extend for a load of up to two bus beats.
// The two beats are concatenated {beat1, beat0}, shifted right by the byte
// offset, and the low 8/16/32/64 bits are sign- or zero-extended to XLEN.
// Ports:
//   beat0_i    first (lower-address) bus beat
//   beat1_i    second beat of a split access, zero otherwise
//   offset_i   byte offset of the load address within beat0
//   size_i     access size
//   unsigned_i 1 = zero-extend, 0 = sign-extend
//   data_o     extended result
module lsu_load_extend
  import lsu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int OFF_W = byte_off_w(XLEN)
) (
  input  logic [XLEN-1:0]  beat0_i,
  input  logic [XLEN-1:0]  beat1_i,
  input  logic [OFF_W-1:0] offset_i,
  input  load_size_e       size_i,
  input  logic             unsigned_i,
  output logic [XLEN-1:0]  data_o
);

  logic [XLEN-1:0] low;
  logic [XLEN-1:0] b_ext;
  logic [XLEN-1:0] h_ext;
  logic [XLEN-1:0] w_ext;
  logic [XLEN-1:0] d_ext;

  // Only the low XLEN bits of the shifted pair are ever needed.
  assign low = XLEN'({beat1_i, beat0_i} >> {offset_i, 3'b000});

  assign b_ext = {{(XLEN-8){~unsigned_i & low[7]}}, low[7:0]};
  assign h_ext = {{(XLEN-16){~unsigned_i & low[15]}}, low[15:0]};

  generate
    if (XLEN == 64) begin : g_x64
      assign w_ext = {{32{~unsigned_i & low[31]}}, low[31:0]};
      assign d_ext = low;
    end else begin : g_x32
      assign w_ext = low;
      // Doubleword on a 32-bit datapath is a fault; data is forced to zero.
      assign d_ext = '0;
    end
  endgenerate

  always_comb begin
    data_o = '0;
    case (size_i)
      LS_B:    data_o = b_ext;
      LS_H:    data_o = h_ext;
      LS_W:    data_o = w_ext;
      default: data_o = d_ext;
    endcase
  end

endmodule

// File: rtl/lsu_load_align_pipe.sv
// Sequential LSU load path: accepts one load at a time, issues one or two
// aligned bus reads, then returns the aligned and extended result with its
// destination tag.
// Configuration macro: MISALIGNED_SPLIT_EN
//   defined     : loads crossing a bus-beat boundary use two bus reads
//   not defined : such loads fault without touching the bus
// Ports:
//   clk_in, reset_in (async, active-high)
//   req_*  : load request handshake (addr, size, unsigned, tag)
//   dm_*   : aligned data-memory read request and in-order read data
//   ld_*   : result handshake (data, tag, fault)
module lsu_load_align_pipe
  import lsu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              req_valid_in,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_in,
  input  logic [1:0]        req_size_in,
  input  logic              req_unsigned_in,
  input  logic [TAG_W-1:0]  req_tag_in,
  output logic              dm_req_valid_o,
  input  logic              dm_req_ready_in,
  output logic [ADDR_W-1:0] dm_addr_o,
  input  logic              dm_rvalid_in,
  input  logic [XLEN-1:0]   dm_rdata_in,
  output logic              ld_valid_o,
  input  logic              ld_ready_in,
  output logic [XLEN-1:0]   ld_data_o,
  output logic [TAG_W-1:0]  ld_tag_o,
  output logic              ld_fault_o
);

  localparam int OFF_W     = byte_off_w(XLEN);
  localparam int BUS_BYTES = XLEN / 8;

  ld_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  load_size_e        size_q;
  logic              uns_q;
  logic [TAG_W-1:0]  tag_q;
  logic              fault_q;
  logic              split_q;
  logic [XLEN-1:0]   beat0_q;
  logic [XLEN-1:0]   beat1_q;

  logic              accept;
  logic [OFF_W-1:0]  req_off;
  logic [3:0]        req_bytes;
  logic [4:0]        req_span;
  logic              req_split;
  logic              req_illegal;
  logic              req_fault;
  logic [ADDR_W-1:0] base_addr;
  logic [XLEN-1:0]   ext_data;

  assign accept = req_valid_in && (state_q == ST_IDLE);

  // Request decode: a load needs two beats when its last byte lies past
  // the end of the beat containing its first byte.
  always_comb begin
    req_off     = req_addr_in[OFF_W-1:0];
    req_bytes   = 4'd1 << req_size_in;
    req_span    = 5'(req_off) + 5'(req_bytes);
    req_split   = req_span > 5'(BUS_BYTES);
    req_illegal = (XLEN == 32) && (load_size_e'(req_size_in) == LS_D);
`ifdef MISALIGNED_SPLIT_EN
    req_fault   = req_illegal;
`else
    req_fault   = req_illegal || req_split;
`endif
  end

  // Request / beat capture registers.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      addr_q  <= '0;
      size_q  <= LS_B;
      uns_q   <= 1'b0;
      tag_q   <= '0;
      fault_q <= 1'b0;
      split_q <= 1'b0;
      beat0_q <= '0;
      beat1_q <= '0;
    end else begin
      if (accept) begin
        addr_q  <= req_addr_in;
        size_q  <= load_size_e'(req_size_in);
        uns_q   <= req_unsigned_in;
        tag_q   <= req_tag_in;
        fault_q <= req_fault;
        split_q <= req_split && !req_fault;
        // beat1 must read as zero for single-beat merges.
        beat0_q <= '0;
        beat1_q <= '0;
      end
      if ((state_q == ST_WAIT0) && dm_rvalid_in) beat0_q <= dm_rdata_in;
      if ((state_q == ST_WAIT1) && dm_rvalid_in) beat1_q <= dm_rdata_in;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (req_valid_in) state_d = req_fault ? ST_RESP : ST_REQ0;
      ST_REQ0:  if (dm_req_ready_in) state_d = ST_WAIT0;
      ST_WAIT0: if (dm_rvalid_in) state_d = split_q ? ST_REQ1 : ST_RESP;
      ST_REQ1:  if (dm_req_ready_in) state_d = ST_WAIT1;
      ST_WAIT1: if (dm_rvalid_in) state_d = ST_RESP;
      ST_RESP:  if (ld_ready_in) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign base_addr = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  // FSM outputs. Result fields are gated to RESP so that they read zero
  // while idle or in flight.
  always_comb begin
    req_ready_o    = 1'b0;
    dm_req_valid_o = 1'b0;
    dm_addr_o      = '0;
    ld_valid_o     = 1'b0;
    ld_data_o      = '0;
    ld_tag_o       = '0;
    ld_fault_o     = 1'b0;
    case (state_q)
      ST_IDLE: req_ready_o = 1'b1;
      ST_REQ0: begin
        dm_req_valid_o = 1'b1;
        dm_addr_o      = base_addr;
      end
      ST_REQ1: begin
        dm_req_valid_o = 1'b1;
        // Wraps modulo 2^ADDR_W by construction.
        dm_addr_o      = base_addr + ADDR_W'(BUS_BYTES);
      end
      ST_RESP: begin
        ld_valid_o = 1'b1;
        ld_tag_o   = tag_q;
        ld_fault_o = fault_q;
        ld_data_o  = fault_q ? '0 : ext_data;
      end
      default: ;
    endcase
  end

  lsu_load_extend #(
    .XLEN  (XLEN),
    .OFF_W (OFF_W)
  ) u_extend (
    .beat0_i    (beat0_q),
    .beat1_i    (beat1_q),
    .offset_i   (addr_q[OFF_W-1:0]),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_o     (ext_data)
  );

endmodule

// File: tb/tb_lsu_load_align_pipe.sv
// Bench for lsu_load_align_pipe: instance 0 is XLEN=32, instance 1 is XLEN=64.
// Expected results come from a byte-addressed memory model and are queued at
// issue time; per-instance monitor and bus-responder processes compare.
module tb_lsu_load_align_pipe;

  localparam int NDUT = 2;
`ifdef MISALIGNED_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int passed = 0;
  int total  = 0;

  // Driven only by the main stimulus process.
  logic        req_valid [NDUT];
  logic [31:0] req_addr  [NDUT];
  logic [1:0]  req_size  [NDUT];
  logic        req_uns   [NDUT];
  logic [4:0]  req_tag   [NDUT];

  // DUT outputs.
  logic        req_ready    [NDUT];
  logic        dm_req_valid [NDUT];
  logic [31:0] dm_addr      [NDUT];
  logic        ld_valid     [NDUT];
  logic [63:0] ld_data      [NDUT];
  logic [4:0]  ld_tag       [NDUT];
  logic        ld_fault     [NDUT];

  bit rand_bp;
  bit hold_rvalid;
  int dm_stall;
  int ld_stall;

  typedef struct {
    logic [63:0] data;
    logic [4:0]  tag;
    logic        fault;
  } exp_t;

  exp_t        exp_q [NDUT][$];
  logic [31:0] bus_q [NDUT][$];

  bit [7:0] mem [bit [31:0]];

  function automatic bit [7:0] get_byte(input bit [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a[7:0] * 8'd37) ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic bit [63:0] get_beat(input bit [31:0] a, input int nbytes);
    bit [63:0] v = '0;
    for (int i = 0; i < nbytes; i++) v[8*i +: 8] = get_byte(a + 32'(i));
    return v;
  endfunction

  task automatic set_bytes(input bit [31:0] a, input bit [63:0] v, input int n);
    for (int i = 0; i < n; i++) mem[a + 32'(i)] = v[8*i +: 8];
  endtask

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
  endfunction

  // Reference: gather the addressed bytes little-endian, then extend.
  function automatic void ref_load(input bit [31:0] addr, input int sz, input bit uns, input int xlen,
                                   output bit [63:0] data, output bit fault, output int nbus,
                                   output bit [31:0] a0);
    int w = xlen / 8;
    int nb = 1 << sz;
    int off = int'(addr % 32'(w));
    bit crosses = (off + nb) > w;
    bit [63:0] v = '0;
    a0 = addr - 32'(off);
    data = '0;
    nbus = 0;
    fault = (xlen == 32 && sz == 3) || (crosses && !SPLIT_EN);
    if (fault) return;
    nbus = crosses ? 2 : 1;
    for (int i = 0; i < nb; i++) v[8*i +: 8] = get_byte(addr + 32'(i));
    if (!uns && nb < 8 && v[8*nb-1]) v = v | (~64'd0 << (8*nb));
    if (xlen == 32) v[63:32] = '0;
    data = v;
  endfunction

  // Call at a negedge. Returns at the negedge following acceptance.
  task automatic issue(input int d, input bit [31:0] addr, input int sz, input bit uns,
                       input bit [4:0] tag, input bit expect_result);
    exp_t e;
    bit [63:0] dat;
    bit f;
    int nbus;
    bit [31:0] a0;
    int n = 0;
    int xlen = (d == 0) ? 32 : 64;
    ref_load(addr, sz, uns, xlen, dat, f, nbus, a0);
    req_valid[d] = 1'b1;
    req_addr[d]  = addr;
    req_size[d]  = 2'(sz);
    req_uns[d]   = uns;
    req_tag[d]   = tag;
    while (!req_ready[d] && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[d]) begin
      total++;
      $display("FAIL accept_timeout dut%0d: req_ready still 0 after %0d cycles", d, n);
    end else begin
      if (nbus >= 1) bus_q[d].push_back(a0);
      if (nbus == 2) bus_q[d].push_back(a0 + 32'(xlen / 8));
      e.data = dat;
      e.tag = tag;
      e.fault = f;
      if (expect_result) exp_q[d].push_back(e);
    end
    @(negedge clk);
    req_valid[d] = 1'b0;
  endtask

  task automatic wait_valid(input int d, input int lat, input string name);
    int n = 1;
    while (!ld_valid[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(n), 64'(lat));
  endtask

  task automatic wait_idle(input int d);
    int n = 0;
    while (!req_ready[d] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[d]) begin
      total++;
      $display("FAIL idle_timeout dut%0d: req_ready still 0 after %0d cycles", d, n);
    end
  endtask

  task automatic directed(input int d, input bit [31:0] addr, input int sz, input bit uns,
                          input bit [4:0] tag, input int lat, input string name);
    issue(d, addr, sz, uns, tag, 1'b1);
    wait_valid(d, lat, name);
    wait_idle(d);
    $display("directed %s dut%0d addr=0x%h size=%0d uns=%0d", name, d, addr, sz, uns);
  endtask

  for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
    localparam int XW = (gi == 0) ? 32 : 64;

    logic          dm_req_ready_l;
    logic          dm_rvalid_l;
    logic          ld_ready_l;
    logic [XW-1:0] dm_rdata_l;
    logic [XW-1:0] ld_data_l;

    lsu_load_align_pipe #(
      .XLEN   (XW),
      .ADDR_W (32),
      .TAG_W  (5)
    ) u_dut (
      .clk_in          (clk),
      .reset_in        (rst),
      .req_valid_in    (req_valid[gi]),
      .req_ready_o     (req_ready[gi]),
      .req_addr_in     (req_addr[gi]),
      .req_size_in     (req_size[gi]),
      .req_unsigned_in (req_uns[gi]),
      .req_tag_in      (req_tag[gi]),
      .dm_req_valid_o  (dm_req_valid[gi]),
      .dm_req_ready_in (dm_req_ready_l),
      .dm_addr_o       (dm_addr[gi]),
      .dm_rvalid_in    (dm_rvalid_l),
      .dm_rdata_in     (dm_rdata_l),
      .ld_valid_o      (ld_valid[gi]),
      .ld_ready_in     (ld_ready_l),
      .ld_data_o       (ld_data_l),
      .ld_tag_o        (ld_tag[gi]),
      .ld_fault_o      (ld_fault[gi])
    );

    assign ld_data[gi] = 64'(ld_data_l);

    // Bus responder: one beat per accepted request, in order.
    initial begin : responder
      bit pend;
      bit [31:0] pend_addr;
      bit prev_wait;
      bit [31:0] prev_addr;
      pend = 1'b0;
      pend_addr = '0;
      prev_wait = 1'b0;
      prev_addr = '0;
      dm_req_ready_l = 1'b0;
      dm_rvalid_l = 1'b0;
      dm_rdata_l = '0;
      forever begin
        @(negedge clk);
        dm_rvalid_l = 1'b0;
        dm_rdata_l = XW'({$urandom, $urandom});
        if (pend && !(gi == 0 && hold_rvalid) && (!rand_bp || $urandom_range(0, 3) != 0)) begin
          dm_rvalid_l = 1'b1;
          dm_rdata_l = XW'(get_beat(pend_addr, XW / 8));
          pend = 1'b0;
        end
        if (prev_wait && dm_req_valid[gi])
          check($sformatf("dm_addr_hold%0d", gi), 64'(dm_addr[gi]), 64'(prev_addr));
        if (gi == 0 && dm_stall > 0) begin
          dm_req_ready_l = 1'b0;
          if (dm_req_valid[gi]) dm_stall--;
        end else begin
          dm_req_ready_l = rand_bp ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
        prev_wait = dm_req_valid[gi] && !dm_req_ready_l;
        prev_addr = dm_addr[gi];
        if (dm_req_valid[gi] && dm_req_ready_l) begin
          if (bus_q[gi].size() == 0) begin
            total++;
            $display("FAIL unexpected_bus_req dut%0d: got addr 0x%h, none expected", gi, dm_addr[gi]);
          end else begin
            check($sformatf("bus_addr%0d", gi), 64'(dm_addr[gi]), 64'(bus_q[gi].pop_front()));
          end
          pend = 1'b1;
          pend_addr = dm_addr[gi];
        end
      end
    end

    // Result monitor / scoreboard.
    initial begin : monitor
      bit held;
      logic [63:0] h_data;
      logic [4:0] h_tag;
      logic h_fault;
      exp_t e;
      held = 1'b0;
      h_data = '0;
      h_tag = '0;
      h_fault = 1'b0;
      ld_ready_l = 1'b0;
      forever begin
        @(negedge clk);
        if (ld_valid[gi] || dm_req_valid[gi])
          check($sformatf("req_ready_busy%0d", gi), 64'(req_ready[gi]), 64'd0);
        if (held && ld_valid[gi]) begin
          check($sformatf("ld_data_hold%0d", gi), ld_data[gi], h_data);
          check($sformatf("ld_tag_hold%0d", gi), 64'(ld_tag[gi]), 64'(h_tag));
          check($sformatf("ld_fault_hold%0d", gi), 64'(ld_fault[gi]), 64'(h_fault));
        end
        if (gi == 0 && ld_stall > 0 && ld_valid[gi]) begin
          ld_ready_l = 1'b0;
          ld_stall--;
        end else begin
          ld_ready_l = rand_bp ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
        if (ld_valid[gi] && ld_ready_l) begin
          if (exp_q[gi].size() == 0) begin
            total++;
            $display("FAIL unexpected_result dut%0d: got data 0x%h tag %0d, none expected",
                     gi, ld_data[gi], ld_tag[gi]);
          end else begin
            e = exp_q[gi].pop_front();
            check($sformatf("ld_data%0d", gi), ld_data[gi], e.data);
            check($sformatf("ld_tag%0d", gi), 64'(ld_tag[gi]), 64'(e.tag));
            check($sformatf("ld_fault%0d", gi), 64'(ld_fault[gi]), 64'(e.fault));
            $display("result dut%0d tag=%0d data=0x%h fault=%0d", gi, ld_tag[gi], ld_data[gi], ld_fault[gi]);
          end
          held = 1'b0;
        end else begin
          held = ld_valid[gi];
          h_data = ld_data[gi];
          h_tag = ld_tag[gi];
          h_fault = ld_fault[gi];
        end
      end
    end
  end

  task automatic check_idle_outputs(input int d, input string tagname);
    check({tagname, "_req_ready"}, 64'(req_ready[d]), 64'd1);
    check({tagname, "_dm_req_valid"}, 64'(dm_req_valid[d]), 64'd0);
    check({tagname, "_dm_addr"}, 64'(dm_addr[d]), 64'd0);
    check({tagname, "_ld_valid"}, 64'(ld_valid[d]), 64'd0);
    check({tagname, "_ld_data"}, ld_data[d], 64'd0);
    check({tagname, "_ld_tag"}, 64'(ld_tag[d]), 64'd0);
    check({tagname, "_ld_fault"}, 64'(ld_fault[d]), 64'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    rst = 1'b1;
    rand_bp = 1'b0;
    hold_rvalid = 1'b0;
    dm_stall = 0;
    ld_stall = 0;
    for (int d = 0; d < NDUT; d++) begin
      req_valid[d] = 1'b0;
      req_addr[d] = '0;
      req_size[d] = '0;
      req_uns[d] = 1'b0;
      req_tag[d] = '0;
    end
    repeat (3) @(negedge clk);
    check_idle_outputs(0, "reset32");
    check_idle_outputs(1, "reset64");
    rst = 1'b0;
    @(negedge clk);

    // Byte loads at offset 3.
    set_bytes(32'h1000, 64'h8012_3456, 4);
    directed(0, 32'h1003, 0, 1'b0, 5'd1, 3, "lat_lb");
    directed(0, 32'h1003, 0, 1'b1, 5'd2, 3, "lat_lbu");
    // Halfword loads at offset 2.
    set_bytes(32'h1000, 64'hBEEF_1234, 4);
    directed(0, 32'h1002, 1, 1'b0, 5'd3, 3, "lat_lh");
    directed(0, 32'h1002, 1, 1'b1, 5'd4, 3, "lat_lhu");
    // Halfword at offset 1 stays within the beat.
    directed(0, 32'h1001, 1, 1'b0, 5'd5, 3, "lat_lh_off1");
    // Illegal size on XLEN=32.
    directed(0, 32'h1000, 3, 1'b0, 5'd6, 1, "lat_ld_illegal");
    // Word crossing a beat boundary.
    set_bytes(32'h1000, 64'h4433_2211_DDCC_BBAA, 8);
    directed(0, 32'h1001, 2, 1'b0, 5'd7, SPLIT_EN ? 5 : 1, "lat_lw_split");
    // Crossing the top of the address space.
    directed(0, 32'hFFFF_FFFE, 2, 1'b1, 5'd8, SPLIT_EN ? 5 : 1, "lat_lw_wrap");

    // Backpressure on both the bus and the result.
    set_bytes(32'h2000, 64'h1234_5678, 4);
    dm_stall = 3;
    ld_stall = 2;
    directed(0, 32'h2000, 2, 1'b0, 5'd10, 6, "lat_backpressure");

    // Reset while waiting for read data; late rvalid must be ignored.
    hold_rvalid = 1'b1;
    issue(0, 32'h3000, 2, 1'b0, 5'd9, 1'b0);
    n = 0;
    while (dm_req_valid[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    hold_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle_outputs(0, $sformatf("post_reset%0d", i));
    end
    $display("directed reset_in_wait0 dut0 addr=0x00003000");

    // XLEN=64 directed loads.
    set_bytes(32'h0008, 64'h8000_0000_0000_0001, 8);
    set_bytes(32'h0000, 64'hFFFF_FFFF_0000_0000, 8);
    directed(1, 32'h0008, 3, 1'b0, 5'd11, 3, "lat_ld64");
    directed(1, 32'h0004, 2, 1'b0, 5'd12, 3, "lat_lw64");
    directed(1, 32'h0004, 2, 1'b1, 5'd13, 3, "lat_lwu64");
    directed(1, 32'h0006, 2, 1'b0, 5'd14, SPLIT_EN ? 5 : 1, "lat_lw64_split");

    // Randomised traffic with random handshake stalls.
    rand_bp = 1'b1;
    for (int i = 0; i < 200; i++) begin
      int d;
      bit [31:0] addr;
      int sz;
      bit uns;
      d = int'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) addr = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      else addr = 32'h4000 + 32'($urandom_range(0, 255));
      sz = int'($urandom_range(0, 3));
      uns = 1'($urandom_range(0, 1));
      issue(d, addr, sz, uns, 5'($urandom_range(0, 31)), 1'b1);
      $display("random dut%0d addr=0x%h size=%0d uns=%0d", d, addr, sz, uns);
    end

    n = 0;
    while ((exp_q[0].size() != 0 || exp_q[1].size() != 0 || !req_ready[0] || !req_ready[1]) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q[0].size() != 0 || exp_q[1].size() != 0) begin
      total++;
      $display("FAIL drain_timeout: %0d/%0d results outstanding, expected 0",
               exp_q[0].size(), exp_q[1].size());
    end
    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
